// File: rtl/pile_colonnes.sv
// Column-height keeper for Pesanteur: counts landed bricks, runs the timed row clear, scores, latches game over.
// All outputs registered (one-cycle latency from any strobe); no backpressure, strobes are consumed every cycle.
module pile_colonnes #(
    parameter int HAUTEUR_MAX  = 7,
    parameter int DUREE_EFFACE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse,
    input  logic       PlusGauche,
    input  logic       PlusCentre,
    input  logic       PlusDroite,
    input  logic       Aligne,
    output logic [2:0] hauteurGauche,
    output logic [2:0] hauteurCentre,
    output logic [2:0] hauteurDroite,
    output logic       Effacement,
    output logic       Pret,
    output logic       Perdu,
    output logic [7:0] Score
);

    typedef enum logic [1:0] {JEU, EFFACE, PERDU} etat_t;

    etat_t           etat_q, etat_d;
    logic [2:0][2:0] haut_q, haut_d;
    logic [2:0]      pend_q, pend_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      score_q, score_d;
    logic            pulse_q, pulse_d;
    logic            eff_q, eff_d;
    logic            pret_q, pret_d;
    logic            perdu_q, perdu_d;
    logic [2:0]      plus;
    logic            tick;
    logic            debord;
    logic            tous_pleins;

    assign plus = {PlusDroite, PlusCentre, PlusGauche};
    assign tick = pulse & ~pulse_q;

    always_comb begin
        etat_d      = etat_q;
        haut_d      = haut_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        pulse_d     = pulse;
        debord      = 1'b0;
        tous_pleins = 1'b1;

        case (etat_q)
            JEU: begin
                for (int i = 0; i < 3; i++) begin
                    if (plus[i]) begin
                        if (haut_q[i] == 3'(HAUTEUR_MAX)) debord = 1'b1;
                        else                              haut_d[i] = haut_q[i] + 3'd1;
                    end
                    if (haut_d[i] == 3'd0) tous_pleins = 1'b0;
                end
                // Overflow wins over a same-cycle Aligne
                if (debord) begin
                    etat_d = PERDU;
                end else if (Aligne && tous_pleins) begin
                    etat_d = EFFACE;
                    cnt_d  = 4'(DUREE_EFFACE);
                    pend_d = 3'b000;
                end
            end
            EFFACE: begin
                pend_d = pend_q | plus;
                if (tick) begin
                    if (cnt_q == 4'd1) begin
                        // Every height is >=1 here, guaranteed by the entry check
                        for (int i = 0; i < 3; i++)
                            haut_d[i] = haut_q[i] - 3'd1 + {2'b00, pend_d[i]};
                        pend_d  = 3'b000;
                        cnt_d   = 4'd0;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        etat_d  = JEU;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: ;
        endcase

        eff_d   = (etat_d == EFFACE);
        pret_d  = (etat_d == JEU);
        perdu_d = (etat_d == PERDU);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            etat_q  <= JEU;
            haut_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            pulse_q <= 1'b0;
            eff_q   <= 1'b0;
            pret_q  <= 1'b1;
            perdu_q <= 1'b0;
        end else begin
            etat_q  <= etat_d;
            haut_q  <= haut_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            eff_q   <= eff_d;
            pret_q  <= pret_d;
            perdu_q <= perdu_d;
        end
    end

    assign hauteurGauche = haut_q[0];
    assign hauteurCentre = haut_q[1];
    assign hauteurDroite = haut_q[2];
    assign Effacement    = eff_q;
    assign Pret          = pret_q;
    assign Perdu         = perdu_q;
    assign Score         = score_q;

endmodule

// File: tb/tb_pile_colonnes.sv
// Directed bench for pile_colonnes: stimulus pushes expected snapshots, a negedge monitor pops and compares.
module tb_pile_colonnes;

    logic       clk = 1'b0;
    logic       reset;
    logic       pulse;
    logic       PlusGauche, PlusCentre, PlusDroite, Aligne;
    logic [2:0] hauteurGauche, hauteurCentre, hauteurDroite;
    logic       Effacement, Pret, Perdu;
    logic [7:0] Score;

    typedef struct packed {
        logic [2:0] hg;
        logic [2:0] hc;
        logic [2:0] hd;
        logic       eff;
        logic       pret;
        logic       perdu;
        logic [7:0] score;
    } snap_t;

    snap_t exp_q[$];
    string nom_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    pile_colonnes #(.HAUTEUR_MAX(7), .DUREE_EFFACE(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pulse         (pulse),
        .PlusGauche    (PlusGauche),
        .PlusCentre    (PlusCentre),
        .PlusDroite    (PlusDroite),
        .Aligne        (Aligne),
        .hauteurGauche (hauteurGauche),
        .hauteurCentre (hauteurCentre),
        .hauteurDroite (hauteurDroite),
        .Effacement    (Effacement),
        .Pret          (Pret),
        .Perdu         (Perdu),
        .Score         (Score)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at the negedge following the posedge that produced them
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            snap_t e, a;
            string n;
            e = exp_q.pop_front();
            n = nom_q.pop_front();
            a = '{hauteurGauche, hauteurCentre, hauteurDroite, Effacement, Pret, Perdu, Score};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got h=%0d,%0d,%0d eff=%b pret=%b perdu=%b score=%0d, expected h=%0d,%0d,%0d eff=%b pret=%b perdu=%b score=%0d",
                         n, a.hg, a.hc, a.hd, a.eff, a.pret, a.perdu, a.score,
                         e.hg, e.hc, e.hd, e.eff, e.pret, e.perdu, e.score);
            end
        end
    end

    task automatic expect_snap(input string n, input int hg, input int hc, input int hd,
                               input logic eff, input logic pret, input logic perdu, input int score);
        snap_t e;
        e = '{3'(hg), 3'(hc), 3'(hd), eff, pret, perdu, 8'(score)};
        exp_q.push_back(e);
        nom_q.push_back(n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic g, input logic c, input logic d, input logic a);
        PlusGauche = g; PlusCentre = c; PlusDroite = d; Aligne = a;
        idle(1);
        PlusGauche = 0; PlusCentre = 0; PlusDroite = 0; Aligne = 0;
    endtask

    // pulse high one cycle out of five
    task automatic tick_pulse();
        pulse = 1'b1;
        idle(1);
        pulse = 1'b0;
        idle(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pulse = 1'b0;
        PlusGauche = 0; PlusCentre = 0; PlusDroite = 0; Aligne = 0;
        idle(5);
        reset = 1'b0;
        expect_snap("reset_state", 0, 0, 0, 0, 1, 0, 0);

        // 1) single centre brick
        strobe(0, 1, 0, 0);
        expect_snap("t1_centre", 0, 1, 0, 0, 1, 0, 0);

        // 2) two full rows, clear one
        do_reset();
        expect_snap("t2_reset", 0, 0, 0, 0, 1, 0, 0);
        strobe(1, 1, 1, 0);
        strobe(1, 1, 1, 0);
        expect_snap("t2_fill", 2, 2, 2, 0, 1, 0, 0);
        strobe(0, 0, 0, 1);
        expect_snap("t2_clear_start", 2, 2, 2, 1, 0, 0, 0);
        repeat (3) tick_pulse();
        expect_snap("t2_after_3_ticks", 2, 2, 2, 1, 0, 0, 0);
        tick_pulse();
        expect_snap("t2_clear_done", 1, 1, 1, 0, 1, 0, 1);

        // 3) Aligne ignored with a gap, then accepted on post-increment heights
        do_reset();
        strobe(1, 0, 1, 0);
        expect_snap("t3_gap", 1, 0, 1, 0, 1, 0, 0);
        strobe(0, 0, 0, 1);
        expect_snap("t3_aligne_ignored", 1, 0, 1, 0, 1, 0, 0);
        strobe(0, 1, 0, 1);
        expect_snap("t3_aligne_with_centre", 1, 1, 1, 1, 0, 0, 0);
        repeat (4) tick_pulse();
        expect_snap("t3_clear_done", 0, 0, 0, 0, 1, 0, 1);

        // 4) pending right column during clear
        strobe(1, 1, 1, 0);
        strobe(0, 0, 1, 0);
        strobe(0, 0, 0, 1);
        strobe(0, 0, 1, 0);
        strobe(0, 0, 1, 0);
        expect_snap("t4_frozen", 1, 1, 2, 1, 0, 0, 1);
        repeat (4) tick_pulse();
        expect_snap("t4_pending_exit", 0, 0, 2, 0, 1, 0, 2);

        // 5) overflow on left column
        do_reset();
        repeat (7) strobe(1, 0, 0, 0);
        expect_snap("t5_left_full", 7, 0, 0, 0, 1, 0, 0);
        strobe(1, 0, 0, 0);
        expect_snap("t5_perdu", 7, 0, 0, 0, 0, 1, 0);
        strobe(1, 1, 1, 1);
        tick_pulse();
        expect_snap("t5_frozen", 7, 0, 0, 0, 0, 1, 0);
        do_reset();
        expect_snap("t5_reset", 0, 0, 0, 0, 1, 0, 0);

        // 6) held pulse counts once; reset mid-clear
        strobe(1, 1, 1, 1);
        pulse = 1'b1;
        idle(10);
        pulse = 1'b0;
        idle(4);
        repeat (2) tick_pulse();
        expect_snap("t6_held_pulse_once", 1, 1, 1, 1, 0, 0, 0);
        tick_pulse();
        expect_snap("t6_exit_after_4", 0, 0, 0, 0, 1, 0, 1);
        strobe(1, 1, 1, 1);
        tick_pulse();
        expect_snap("t6_mid_clear", 1, 1, 1, 1, 0, 0, 1);
        reset = 1'b1;
        idle(1);
        expect_snap("t6_reset_mid_clear", 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b0;

        idle(3);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
